id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX boundary stage. It consumes the registered forwarding results (per-operand select plus data) and the register-file read data, then resolves the final rs/rt operands.
- Keeps resolved operands stable across multi-cycle stalls and registers them into the EX stage.
- Detects load-use hazards against the instruction currently in EX and raises a stall request to the stall controller.

Parameters:
- LOAD_LAT, 1, number of stall cycles requested per load-use hazard (1..7).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush (exception/ERET).
- stall  in  6  stall bus; stall[2]=ID held, stall[3]=EX held.
- id_valid  in  1  ID holds a valid instruction.
- id_pc  in  32  ID instruction PC.
- id_rs_re, id_rt_re  in  1 each  instruction reads rs/rt.
- id_rs_raddr, id_rt_raddr  in  5 each  source register numbers.
- rs_rdata, rt_rdata  in  32 each  register-file read data.
- sel_rs_forward_r, sel_rt_forward_r  in  1 each  registered forward select.
- rs_forward_data_r, rt_forward_data_r  in  32 each  registered forward data.
- id_imm32  in  32  extended immediate.
- id_sel_src2_imm  in  1  src2 takes the immediate.
- id_we  in  1  writes the register file.
- id_waddr  in  5  destination register.
- id_is_load  in  1  instruction is a load.
- ex_valid  out  1  EX holds a valid instruction.
- ex_pc  out  32  EX PC.
- ex_src1  out  32  ALU source 1 (resolved rs).
- ex_src2  out  32  ALU source 2 (resolved rt or immediate).
- ex_rt_data  out  32  resolved rt (store data).
- ex_we  out  1  EX write enable.
- ex_waddr  out  5  EX destination register.
- ex_is_load  out  1  EX is a load.
- stallreq_load  out  1  load-use stall request (combinational).

Behaviour:
Operand resolution (combinational):
- res_rs = 0 if id_rs_raddr==0; else rs_forward_data_r if sel_rs_forward_r; else rs_rdata. res_rt is resolved the same way.
- Register 0 always reads as 0, even when a forward select is high.

Stall hold buffers (per operand: hold_v, hold_data):
- Operand presented to EX = hold_data if hold_v, else res_x.
- When stall[2]=1, hold_v=0 and no flush: hold_data<=res_x, hold_v<=1. The first stalled cycle's value is frozen.
- When stall[2]=0, flush or rst: hold_v<=0.

EX register update, priority in this order:
- rst or flush: all outputs 0.
- stall[2]=1 and stall[3]=0: bubble. ex_valid, ex_we and ex_is_load go to 0; ex_waddr goes to 0; data fields are don't-care but driven to 0.
- stall[2]=0: load from ID. ex_valid<=id_valid. ex_we/ex_is_load are gated by id_valid. ex_src1<=presented rs. ex_rt_data<=presented rt. ex_src2<=id_imm32 if id_sel_src2_imm, else presented rt.
- Otherwise: hold.
- Latency: one cycle ID to EX.

Load-use FSM (states IDLE, WAIT; 3-bit counter cnt):
- hazard = id_valid & ex_valid & ex_is_load & ex_we & ex_waddr!=0 & ((id_rs_re & id_rs_raddr==ex_waddr) | (id_rt_re & id_rt_raddr==ex_waddr)).
- IDLE: stallreq_load = hazard. If hazard and LOAD_LAT>1, go to WAIT with cnt<=LOAD_LAT-1.
- WAIT: stallreq_load=1; cnt decrements each cycle; return to IDLE when cnt==1.
- flush or rst forces IDLE with cnt=0 and stallreq_load=0 in that cycle.
- A hazard re-detected in the cycle after WAIT exits starts a new sequence.

Reset values: all outputs 0, FSM IDLE, hold_v=0.

Test Plan:
- Reset: assert rst 2 cycles with nonzero inputs -> all ex_* outputs 0, stallreq_load 0, hold_v 0.
- Register-0 suppression: id_rs_raddr=0, sel_rs_forward_r=1, rs_forward_data_r=0xDEADBEEF, no stall -> next cycle ex_src1=0.
- Forward vs regfile selection: rt forward select 1 with data 0x11, rt_rdata 0x22, id_sel_src2_imm=0 -> ex_src2=0x11 and ex_rt_data=0x11. Then forward select 0 -> ex_src2=0x22.
- Stall hold: stall[2]=stall[3]=1 for 3 cycles. Forward data changes 0xA->0xB->0xC starting in the first stalled cycle. Release -> ex_src1=0xA and EX unchanged during the stall.
- Bubble: stall=6'b000111 for one cycle -> ex_valid=0 and ex_we=0. ID contents enter EX after release.
- Load-use with LOAD_LAT=2: EX holds a load to r5 and ID reads rs=r5 -> stallreq_load high exactly 2 cycles. Repeat with flush in the 2nd cycle -> stallreq_load 0 that cycle and FSM IDLE.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX boundary: resolves rs/rt operands (r0, forward, regfile), freezes them across
// ID stalls, registers the instruction into EX and raises load-use stall requests.
module id_ex_operand_stage #(
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [5:0]  stall,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic        id_rs_re,
  input  logic        id_rt_re,
  input  logic [4:0]  id_rs_raddr,
  input  logic [4:0]  id_rt_raddr,
  input  logic [31:0] rs_rdata,
  input  logic [31:0] rt_rdata,
  input  logic        sel_rs_forward_r,
  input  logic        sel_rt_forward_r,
  input  logic [31:0] rs_forward_data_r,
  input  logic [31:0] rt_forward_data_r,
  input  logic [31:0] id_imm32,
  input  logic        id_sel_src2_imm,
  input  logic        id_we,
  input  logic [4:0]  id_waddr,
  input  logic        id_is_load,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_src1,
  output logic [31:0] ex_src2,
  output logic [31:0] ex_rt_data,
  output logic        ex_we,
  output logic [4:0]  ex_waddr,
  output logic        ex_is_load,
  output logic        stallreq_load
);

  localparam logic [2:0] LOAD_CNT_INIT = 3'(LOAD_LAT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  // Operand index 0 is rs, index 1 is rt.
  logic [4:0]  op_raddr     [2];
  logic [31:0] op_rdata     [2];
  logic [31:0] op_fwd_data  [2];
  logic        op_fwd_sel   [2];
  logic [31:0] op_presented [2];

  assign op_raddr[0]    = id_rs_raddr;
  assign op_raddr[1]    = id_rt_raddr;
  assign op_rdata[0]    = rs_rdata;
  assign op_rdata[1]    = rt_rdata;
  assign op_fwd_data[0] = rs_forward_data_r;
  assign op_fwd_data[1] = rt_forward_data_r;
  assign op_fwd_sel[0]  = sel_rs_forward_r;
  assign op_fwd_sel[1]  = sel_rt_forward_r;

  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall[5:4], stall[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      logic [31:0] op_res;
      logic        hold_v_reg;
      logic [31:0] hold_data_reg;

      // r0 wins over a forward select: a stale forward to r0 must never leak.
      assign op_res = (op_raddr[gi] == 5'd0) ? 32'd0 :
                      op_fwd_sel[gi]         ? op_fwd_data[gi] : op_rdata[gi];
      assign op_presented[gi] = hold_v_reg ? hold_data_reg : op_res;

      always_ff @(posedge clk) begin
        if (rst || flush || !stall[2]) begin
          hold_v_reg <= 1'b0;
        end else if (!hold_v_reg) begin
          hold_v_reg    <= 1'b1;
          hold_data_reg <= op_res;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush || (stall[2] && !stall[3])) begin
      ex_valid   <= 1'b0;
      ex_pc      <= 32'd0;
      ex_src1    <= 32'd0;
      ex_src2    <= 32'd0;
      ex_rt_data <= 32'd0;
      ex_we      <= 1'b0;
      ex_waddr   <= 5'd0;
      ex_is_load <= 1'b0;
    end else if (!stall[2]) begin
      ex_valid   <= id_valid;
      ex_pc      <= id_pc;
      ex_src1    <= op_presented[0];
      ex_src2    <= id_sel_src2_imm ? id_imm32 : op_presented[1];
      ex_rt_data <= op_presented[1];
      ex_we      <= id_we & id_valid;
      ex_waddr   <= id_waddr;
      ex_is_load <= id_is_load & id_valid;
    end
  end

  logic       hazard;
  state_t     state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;

  assign hazard = id_valid & ex_valid & ex_is_load & ex_we & (ex_waddr != 5'd0) &
                  ((id_rs_re & (id_rs_raddr == ex_waddr)) |
                   (id_rt_re & (id_rt_raddr == ex_waddr)));

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    stallreq_load = 1'b0;
    if (rst || flush) begin
      state_next = IDLE;
      cnt_next   = 3'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          stallreq_load = hazard;
          if (hazard && (LOAD_LAT > 1)) begin
            state_next = WAIT;
            cnt_next   = LOAD_CNT_INIT;
          end
        end
        WAIT: begin
          stallreq_load = 1'b1;
          cnt_next      = cnt_reg - 3'd1;
          if (cnt_reg <= 3'd1) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage (LOAD_LAT=2): operand resolution, stall hold,
// bubbles and the load-use stall request sequence.
module tb_id_ex_operand_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [5:0]  stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic        id_rs_re, id_rt_re;
  logic [4:0]  id_rs_raddr, id_rt_raddr;
  logic [31:0] rs_rdata, rt_rdata;
  logic        sel_rs_forward_r, sel_rt_forward_r;
  logic [31:0] rs_forward_data_r, rt_forward_data_r;
  logic [31:0] id_imm32;
  logic        id_sel_src2_imm;
  logic        id_we;
  logic [4:0]  id_waddr;
  logic        id_is_load;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_src1, ex_src2, ex_rt_data;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic        ex_is_load;
  logic        stallreq_load;

  int errors = 0;
  int checks = 0;

  id_ex_operand_stage #(.LOAD_LAT(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs_re(id_rs_re), .id_rt_re(id_rt_re),
    .id_rs_raddr(id_rs_raddr), .id_rt_raddr(id_rt_raddr),
    .rs_rdata(rs_rdata), .rt_rdata(rt_rdata),
    .sel_rs_forward_r(sel_rs_forward_r), .sel_rt_forward_r(sel_rt_forward_r),
    .rs_forward_data_r(rs_forward_data_r), .rt_forward_data_r(rt_forward_data_r),
    .id_imm32(id_imm32), .id_sel_src2_imm(id_sel_src2_imm),
    .id_we(id_we), .id_waddr(id_waddr), .id_is_load(id_is_load),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_src1(ex_src1), .ex_src2(ex_src2),
    .ex_rt_data(ex_rt_data), .ex_we(ex_we), .ex_waddr(ex_waddr),
    .ex_is_load(ex_is_load), .stallreq_load(stallreq_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; stall = 6'b000100;
    id_valid = 1'b1; id_pc = 32'h100; id_we = 1'b1; id_waddr = 5'd7; id_is_load = 1'b1;
    id_rs_re = 1'b1; id_rt_re = 1'b1; id_rs_raddr = 5'd1; id_rt_raddr = 5'd2;
    rs_rdata = 32'h1; rt_rdata = 32'h2; sel_rs_forward_r = 1'b1; sel_rt_forward_r = 1'b1;
    rs_forward_data_r = 32'h3; rt_forward_data_r = 32'h4; id_imm32 = 32'h5; id_sel_src2_imm = 1'b1;
    tick();
    tick();
    checks++;
    if ({ex_valid, ex_we, ex_is_load, ex_waddr} !== 8'd0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0", {ex_valid, ex_we, ex_is_load, ex_waddr});
    end
    checks++;
    if ({ex_pc, ex_src1, ex_src2, ex_rt_data} !== 128'd0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {ex_pc, ex_src1, ex_src2, ex_rt_data});
    end
    checks++;
    if (stallreq_load !== 1'b0) begin
      errors++; $display("FAIL reset_stallreq: got %b expected 0", stallreq_load);
    end
    checks++;
    if ({dut.g_operand[0].hold_v_reg, dut.g_operand[1].hold_v_reg} !== 2'b00) begin
      errors++; $display("FAIL reset_hold_v: got %b expected 00",
                         {dut.g_operand[0].hold_v_reg, dut.g_operand[1].hold_v_reg});
    end
    rst = 1'b0; stall = 6'b000000; id_we = 1'b0; id_is_load = 1'b0;
    id_rs_re = 1'b0; id_rt_re = 1'b0; id_sel_src2_imm = 1'b0;
    $display("test_reset done: errors=%0d", errors);
  endtask

  task automatic test_reg0();
    id_valid = 1'b1; id_pc = 32'h200; id_rs_raddr = 5'd0;
    sel_rs_forward_r = 1'b1; rs_forward_data_r = 32'hDEADBEEF; rs_rdata = 32'h1234;
    tick();
    checks++;
    if (ex_src1 !== 32'd0) begin
      errors++; $display("FAIL reg0_src1: got %h expected 00000000", ex_src1);
    end
    checks++;
    if ({ex_valid, ex_pc} !== {1'b1, 32'h200}) begin
      errors++; $display("FAIL reg0_pc: got %b/%h expected 1/00000200", ex_valid, ex_pc);
    end
    $display("test_reg0 done: errors=%0d", errors);
  endtask

  task automatic test_forward_select();
    id_rt_raddr = 5'd4; sel_rt_forward_r = 1'b1; rt_forward_data_r = 32'h11; rt_rdata = 32'h22;
    id_imm32 = 32'h99; id_sel_src2_imm = 1'b0;
    tick();
    checks++;
    if ({ex_src2, ex_rt_data} !== {32'h11, 32'h11}) begin
      errors++; $display("FAIL fwd_sel1: got %h/%h expected 11/11", ex_src2, ex_rt_data);
    end
    sel_rt_forward_r = 1'b0;
    tick();
    checks++;
    if ({ex_src2, ex_rt_data} !== {32'h22, 32'h22}) begin
      errors++; $display("FAIL fwd_sel0: got %h/%h expected 22/22", ex_src2, ex_rt_data);
    end
    id_sel_src2_imm = 1'b1;
    tick();
    checks++;
    if ({ex_src2, ex_rt_data} !== {32'h99, 32'h22}) begin
      errors++; $display("FAIL fwd_imm: got %h/%h expected 99/22", ex_src2, ex_rt_data);
    end
    id_sel_src2_imm = 1'b0; id_rt_raddr = 5'd0; sel_rt_forward_r = 1'b1;
    tick();
    checks++;
    if (ex_rt_data !== 32'd0) begin
      errors++; $display("FAIL fwd_rt_r0: got %h expected 00000000", ex_rt_data);
    end
    $display("test_forward_select done: errors=%0d", errors);
  endtask

  task automatic test_stall_hold();
    logic [31:0] fwd_seq [3];
    fwd_seq[0] = 32'hA; fwd_seq[1] = 32'hB; fwd_seq[2] = 32'hC;
    id_rs_raddr = 5'd3; sel_rs_forward_r = 1'b1; rs_forward_data_r = 32'h5; id_pc = 32'h300;
    tick();
    checks++;
    if (ex_src1 !== 32'h5) begin
      errors++; $display("FAIL hold_pre: got %h expected 00000005", ex_src1);
    end
    id_pc = 32'h304; stall = 6'b001100;
    for (int i = 0; i < 3; i++) begin
      rs_forward_data_r = fwd_seq[i];
      tick();
      checks++;
      if ({ex_src1, ex_pc} !== {32'h5, 32'h300}) begin
        errors++; $display("FAIL hold_ex_frozen%0d: got %h/%h expected 00000005/00000300", i, ex_src1, ex_pc);
      end
    end
    stall = 6'b000000;
    tick();
    checks++;
    if ({ex_src1, ex_pc} !== {32'hA, 32'h304}) begin
      errors++; $display("FAIL hold_release: got %h/%h expected 0000000a/00000304", ex_src1, ex_pc);
    end
    $display("test_stall_hold done: errors=%0d", errors);
  endtask

  task automatic test_bubble();
    id_valid = 1'b1; id_we = 1'b1; id_waddr = 5'd9; id_pc = 32'h400;
    tick();
    id_pc = 32'h404; stall = 6'b000111;
    tick();
    checks++;
    if ({ex_valid, ex_we, ex_waddr} !== 7'd0) begin
      errors++; $display("FAIL bubble: got %b/%b/%0d expected 0/0/0", ex_valid, ex_we, ex_waddr);
    end
    stall = 6'b000000;
    tick();
    checks++;
    if ({ex_valid, ex_we, ex_waddr, ex_pc} !== {1'b1, 1'b1, 5'd9, 32'h404}) begin
      errors++; $display("FAIL bubble_release: got %b/%b/%0d/%h expected 1/1/9/00000404",
                         ex_valid, ex_we, ex_waddr, ex_pc);
    end
    $display("test_bubble done: errors=%0d", errors);
  endtask

  task automatic load_into_ex(input logic [4:0] dst, input logic [31:0] pc);
    stall = 6'b000000; id_valid = 1'b1; id_pc = pc; id_we = 1'b1; id_waddr = dst;
    id_is_load = 1'b1; id_rs_re = 1'b0; id_rt_re = 1'b0;
    tick();
    id_is_load = 1'b0; id_waddr = 5'd6; id_pc = pc + 32'd4;
  endtask

  task automatic test_load_use();
    load_into_ex(5'd5, 32'h500);
    id_rs_re = 1'b1; id_rs_raddr = 5'd5; stall = 6'b000111;
    #1;
    checks++;
    if (stallreq_load !== 1'b1) begin
      errors++; $display("FAIL lu_cycle1: got %b expected 1", stallreq_load);
    end
    tick();
    checks++;
    if ({stallreq_load, ex_valid} !== 2'b10) begin
      errors++; $display("FAIL lu_cycle2: got stallreq=%b ex_valid=%b expected 1/0", stallreq_load, ex_valid);
    end
    tick();
    checks++;
    if (stallreq_load !== 1'b0) begin
      errors++; $display("FAIL lu_cycle3: got %b expected 0", stallreq_load);
    end
    $display("test_load_use done: errors=%0d", errors);
  endtask

  task automatic test_load_use_flush();
    load_into_ex(5'd5, 32'h600);
    id_rt_re = 1'b1; id_rt_raddr = 5'd5; stall = 6'b000111;
    #1;
    checks++;
    if (stallreq_load !== 1'b1) begin
      errors++; $display("FAIL luf_cycle1: got %b expected 1", stallreq_load);
    end
    tick();
    flush = 1'b1;
    #1;
    checks++;
    if (stallreq_load !== 1'b0) begin
      errors++; $display("FAIL luf_flush_cycle: got %b expected 0", stallreq_load);
    end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if ({int'(dut.state_reg) == 0, ex_valid, stallreq_load} !== 3'b100) begin
      errors++; $display("FAIL luf_after: got idle=%b ex_valid=%b stallreq=%b expected 1/0/0",
                         int'(dut.state_reg) == 0, ex_valid, stallreq_load);
    end
    load_into_ex(5'd0, 32'h700);
    id_rs_re = 1'b1; id_rs_raddr = 5'd0;
    #1;
    checks++;
    if ({ex_is_load, stallreq_load} !== 2'b10) begin
      errors++; $display("FAIL lu_r0: got is_load=%b stallreq=%b expected 1/0", ex_is_load, stallreq_load);
    end
    $display("test_load_use_flush done: errors=%0d", errors);
  endtask

  initial begin
    test_reset();
    test_reg0();
    test_forward_select();
    test_stall_hold();
    test_bubble();
    test_load_use();
    test_load_use_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
